// File: rtl/mult16_accumulator.sv
// Frame accumulator for a 16x16 multiplier: sums `len` unsigned products into an ACC_W-bit register.
// Define MULT16_ACC_SATURATE_EN to clamp acc at all-ones on overflow; otherwise acc wraps modulo 2^ACC_W.
module mult16_accumulator #(
  parameter int unsigned ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned PAD_W = SUM_W - 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       len_q;
  logic [7:0]       count;
  logic [7:0]       count_inc;
  logic             xfer;
  logic             last;
  logic             accept_start;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;

  // One extra sum bit captures the carry out of the accumulator.
  assign sum          = {1'b0, acc} + {{PAD_W{1'b0}}, prod};
  assign count_inc    = count + 8'd1;
  assign last         = (count_inc == len_q);
  assign xfer         = prod_valid && prod_ready;
  assign accept_start = (state == IDLE) && start;

`ifdef MULT16_ACC_SATURATE_EN
  assign acc_nxt = (overflow || sum[ACC_W]) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_nxt = sum[ACC_W-1:0];
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == 8'd0) ? DONE : ACCUM;
      ACCUM:   if (xfer && last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register
  always_comb begin
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      ACCUM: begin
        prod_ready = 1'b1;
        busy       = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame datapath: acc, count, latched length and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= 8'd0;
      count    <= 8'd0;
      acc      <= {ACC_W{1'b0}};
      overflow <= 1'b0;
    end else if (accept_start) begin
      len_q    <= len;
      count    <= 8'd0;
      acc      <= {ACC_W{1'b0}};
      overflow <= 1'b0;
    end else if (xfer) begin
      count <= count_inc;
      acc   <= acc_nxt;
      if (sum[ACC_W]) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mult16_accumulator.sv
// Self-checking bench: a 40-bit and a 33-bit instance share stimulus and are checked
// every cycle against an exact-integer model of the frame sum.
module tb_mult16_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [31:0] prod;
  logic        prod_valid;
  logic        out_ready;

  logic        prod_ready_a, out_valid_a, busy_a, overflow_a;
  logic [39:0] acc_a;
  logic        prod_ready_b, out_valid_b, busy_b, overflow_b;
  logic [32:0] acc_b;

  int n_cmp;
  int n_err;
  logic [31:0] prods [0:255];

  mult16_accumulator #(.ACC_W(40)) dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready_a), .acc(acc_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .busy(busy_a),
    .overflow(overflow_a)
  );

  mult16_accumulator #(.ACC_W(33)) dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
    .prod_valid(prod_valid), .prod_ready(prod_ready_b), .acc(acc_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .busy(busy_b),
    .overflow(overflow_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact sum s, reduced to a w-bit accumulator value
  function automatic logic [63:0] exp_acc(input logic [71:0] s, input int w);
    logic [71:0] mx;
    mx = (72'd1 << w) - 72'd1;
`ifdef MULT16_ACC_SATURATE_EN
    if (s > mx) return mx[63:0];
`endif
    return 64'(s & mx);
  endfunction

  function automatic logic exp_ovf(input logic [71:0] s, input int w);
    logic [71:0] mx;
    mx = (72'd1 << w) - 72'd1;
    return s > mx;
  endfunction

  task automatic idle_inputs();
    start      = 1'b0;
    len        = 8'd0;
    prod       = 32'd0;
    prod_valid = 1'b0;
    out_ready  = 1'b0;
  endtask

  // Drives one whole frame (n products from prods[]) and checks both instances every cycle.
  // gap < 0 selects random 0..2 idle cycles between transfers; hold is DONE cycles before out_ready.
  task automatic do_frame(input string name, input int n, input int gap, input int hold,
                          input bit start_in_done);
    logic [71:0] s;
    logic [39:0] e40;
    logic [32:0] e33;
    logic        o40, o33, e_busy, e_ov, e_pr;
    int k, g, h, ph, exp_st, cyc;
    bit fin;
    s = 72'd0; k = 0; h = 0; ph = 0; cyc = 0; fin = 1'b0; exp_st = 0;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    while (!fin) begin
      idle_inputs();
      prod = $urandom;
      case (ph)
        0: begin
          start  = 1'b1;
          len    = 8'(n);
          exp_st = (n == 0) ? 2 : 1;
          ph     = (n == 0) ? 2 : 1;
        end
        1: begin
          start = 1'($urandom_range(0, 1));
          len   = 8'($urandom);
          if (g > 0) begin
            g--;
            exp_st = 1;
          end else begin
            prod_valid = 1'b1;
            prod       = prods[k];
            s          = s + 72'(prods[k]);
            k++;
            g      = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            exp_st = (k == n) ? 2 : 1;
            if (k == n) ph = 2;
          end
        end
        2: begin
          prod_valid = 1'($urandom_range(0, 1));
          if (h < hold) begin
            h++;
            start  = 1'($urandom_range(0, 1));
            len    = 8'($urandom);
            exp_st = 2;
          end else begin
            out_ready = 1'b1;
            start     = start_in_done;
            len       = 8'd3;
            exp_st    = 0;
            ph        = 3;
          end
        end
        default: begin
          prod_valid = 1'b1;
          exp_st     = 0;
          fin        = 1'b1;
        end
      endcase
      @(posedge clk);
      #1;
      cyc++;
      e_busy = (exp_st != 0);
      e_ov   = (exp_st == 2);
      e_pr   = (exp_st == 1);
      e40    = 40'(exp_acc(s, 40));
      e33    = 33'(exp_acc(s, 33));
      o40    = exp_ovf(s, 40);
      o33    = exp_ovf(s, 33);
      n_cmp++;
      if ({busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a} !== {e_busy, e_ov, e_pr, o40, e40}) begin
        n_err++;
        $display("FAIL %s cyc%0d w40: got busy=%b oval=%b prdy=%b ovf=%b acc=%h, want busy=%b oval=%b prdy=%b ovf=%b acc=%h",
                 name, cyc, busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a, e_busy, e_ov, e_pr, o40, e40);
      end
      n_cmp++;
      if ({busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b} !== {e_busy, e_ov, e_pr, o33, e33}) begin
        n_err++;
        $display("FAIL %s cyc%0d w33: got busy=%b oval=%b prdy=%b ovf=%b acc=%h, want busy=%b oval=%b prdy=%b ovf=%b acc=%h",
                 name, cyc, busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b, e_busy, e_ov, e_pr, o33, e33);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_w40: got %h, want 0", {busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a});
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_w33: got %h, want 0", {busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    prods[0] = 32'd10; prods[1] = 32'd20; prods[2] = 32'd30;
    do_frame("basic", 3, 0, 0, 1'b0);
  endtask

  task automatic test_gaps();
    prods[0] = 32'd39812471; prods[1] = 32'd39812471;
    do_frame("gaps", 2, 2, 5, 1'b0);
  endtask

  task automatic test_len_zero();
    do_frame("len_zero", 0, 0, 2, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 256; i++) prods[i] = 32'hFFFF_FFFF;
    do_frame("ovf3", 3, 0, 1, 1'b0);
    do_frame("ovf255", 255, 0, 0, 1'b0);
    for (int i = 0; i < 255; i++) prods[i] = $urandom;
    do_frame("rand255", 255, -1, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    start = 1'b1;
    len   = 8'd4;
    @(posedge clk);
    #1;
    idle_inputs();
    prod_valid = 1'b1;
    prod       = $urandom | 32'd1;
    @(posedge clk);
    #1;
    idle_inputs();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a} !== 44'd0) begin
      n_err++;
      $display("FAIL reset_mid_w40: got %h, want 0", {busy_a, out_valid_a, prod_ready_a, overflow_a, acc_a});
    end
    n_cmp++;
    if ({busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b} !== 37'd0) begin
      n_err++;
      $display("FAIL reset_mid_w33: got %h, want 0", {busy_b, out_valid_b, prod_ready_b, overflow_b, acc_b});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    prods[0] = 32'd7;
    do_frame("after_rst", 1, 0, 0, 1'b0);
  endtask

  task automatic test_start_in_done();
    prods[0] = 32'd5; prods[1] = 32'd6;
    do_frame("start_in_done", 2, 1, 2, 1'b1);
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 25; f++) begin
      n = int'($urandom_range(0, 12));
      for (int i = 0; i < n; i++)
        prods[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      do_frame("random", n, -1, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_len_zero();
    test_overflow();
    test_reset_mid();
    test_start_in_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult16_accumulator.md
MULT16_ACCUMULATOR -- requirements
Module: mult16_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator width in bits, legal range 33..64.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: begin a frame; sampled only in IDLE.
REQ-005 SHALL have port len, input, 8 bits: number of products in the frame; latched on an accepted start.
REQ-006 SHALL have port prod, input, 32 bits: unsigned product from the 16x16 multiplier stage.
REQ-007 SHALL have port prod_valid, input, 1 bit: prod is valid this cycle.
REQ-008 SHALL have port prod_ready, output, 1 bit: block accepts prod this cycle.
REQ-009 SHALL have port acc, output, ACC_W bits: running sum, which is the frame result in DONE.
REQ-010 SHALL have port out_valid, output, 1 bit: acc holds the final frame result.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag; the current frame's sum exceeded 2^ACC_W-1.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, ACCUM and DONE.
REQ-015 In IDLE, start=1 SHALL do all of the following on the same edge: latch len, clear acc, clear overflow and the count, and enter ACCUM (len!=0) or DONE (len==0).
REQ-016 In ACCUM, prod_ready SHALL be 1 combinationally; it SHALL be 0 in IDLE and DONE.
REQ-017 A transfer SHALL occur when prod_valid and prod_ready are both 1; on that edge acc <= acc + zero-extended prod, and count increments.
REQ-018 A prod_valid=0 cycle in ACCUM SHALL leave acc and count unchanged, with no timeout.
REQ-019 On the transfer that makes count equal the latched len, the FSM SHALL enter DONE; out_valid SHALL assert the next cycle.
REQ-020 In DONE, out_valid SHALL be 1 and acc/overflow SHALL hold stable until out_ready=1, which returns the FSM to IDLE on that edge.
REQ-021 In DONE and IDLE, acc and overflow SHALL retain their last values; start SHALL be ignored outside IDLE, including start and out_ready both high in DONE.
REQ-022 Count SHALL be 8 bits wide, and len=255 SHALL accumulate exactly 255 products.
REQ-023 Overflow SHALL be set on any transfer whose unbounded sum exceeds 2^ACC_W-1, and cleared only by reset or an accepted start.
REQ-024 prod SHALL be registered nowhere else; the sole latency is one edge per transfer.

Reset
REQ-025 rst=1 SHALL asynchronously force state=IDLE, acc=0, count=0, overflow=0, out_valid=0, prod_ready=0 and busy=0.
REQ-026 Reset asserted mid-ACCUM or mid-DONE SHALL discard the frame.
REQ-027 The first start after rst deasserts SHALL be honoured on the first clock edge.

Configuration
REQ-028 Macro MULT16_ACC_SATURATE_EN defined: on overflow, acc SHALL clamp to all-ones and hold there for the rest of the frame.
REQ-029 Macro MULT16_ACC_SATURATE_EN undefined: acc SHALL wrap modulo 2^ACC_W.
REQ-030 The overflow flag SHALL behave identically in both builds.

Verification
REQ-031 Scenario: start, len=3, prods 10, 20, 30 back-to-back -> out_valid one cycle after the 3rd transfer, acc=60, overflow=0.
REQ-032 Scenario: len=2, prod=39812471 (10097*3943) twice, prod_valid gaps of 2 cycles, out_ready held low 5 cycles -> acc=79624942, out_valid held stable, then IDLE after out_ready.
REQ-033 Scenario: len=0 -> DONE on the next edge, out_valid=1, acc=0, prod_ready never asserted.
REQ-034 Scenario: ACC_W=33, len=3, prod=0xFFFFFFFF x3 -> overflow=1; acc=0x1FFFFFFFF with MULT16_ACC_SATURATE_EN defined, acc=0x0FFFFFFFD with it undefined.
REQ-035 Scenario: rst pulsed after 1 of 4 transfers -> all outputs 0 immediately; a new start with len=1, prod=7 -> acc=7.
REQ-036 Scenario: start and out_ready both high in DONE -> FSM returns to IDLE, start is ignored, busy=0 the next cycle.
